// File: rtl/issue_unit_pkg.sv
// Shared definitions for the issue stage: class and instruction enumerations, RV32I opcodes, ROB sizing.
// Latency: none (constants only). Backpressure: n/a.
// Consumers pick these up with import issue_unit_pkg::*.
package issue_unit_pkg;

    localparam int ROBIDBW = 4;
    localparam int RSSZ    = 8;

    localparam logic True  = 1'b1;
    localparam logic False = 1'b0;

    localparam logic [2:0] ART  = 3'd0;
    localparam logic [2:0] ARTI = 3'd1;
    localparam logic [2:0] UPP  = 3'd2;
    localparam logic [2:0] JMP  = 3'd3;
    localparam logic [2:0] BRC  = 3'd4;
    localparam logic [2:0] LD   = 3'd5;
    localparam logic [2:0] ST   = 3'd6;

    localparam logic [5:0] ILLEGAL = 6'd0;
    localparam logic [5:0] LUI   = 6'd1,  AUIPC = 6'd2,  JAL   = 6'd3,  JALR  = 6'd4;
    localparam logic [5:0] BEQ   = 6'd5,  BNE   = 6'd6,  BLT   = 6'd7,  BGE   = 6'd8;
    localparam logic [5:0] BLTU  = 6'd9,  BGEU  = 6'd10;
    localparam logic [5:0] LB    = 6'd11, LH    = 6'd12, LW    = 6'd13, LBU   = 6'd14;
    localparam logic [5:0] LHU   = 6'd15;
    localparam logic [5:0] SB    = 6'd16, SH    = 6'd17, SW    = 6'd18;
    localparam logic [5:0] ADDI  = 6'd19, SLTI  = 6'd20, SLTIU = 6'd21, XORI  = 6'd22;
    localparam logic [5:0] ORI   = 6'd23, ANDI  = 6'd24, SLLI  = 6'd25, SRLI  = 6'd26;
    localparam logic [5:0] SRAI  = 6'd27;
    localparam logic [5:0] ADD   = 6'd28, SUB   = 6'd29, SLL   = 6'd30, SLT   = 6'd31;
    localparam logic [5:0] SLTU  = 6'd32, XOR   = 6'd33, SRL   = 6'd34, SRA   = 6'd35;
    localparam logic [5:0] OR    = 6'd36, AND   = 6'd37;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    // Loads and stores go to the load/store buffer, everything up to BRC to the station.
    function automatic logic goes_to_lsb(input logic [2:0] t);
        return t > BRC;
    endfunction

endpackage

// File: rtl/issue_unit_inst_decoder.sv
// RV32I decoder: instruction word to register fields, sign-extended immediate, code and class.
// Latency: combinational. Backpressure: n/a.
// Fields the format does not use read 0; unrecognised words produce code ILLEGAL.
module inst_decoder
    import issue_unit_pkg::*;
(
    input  logic [31:0] inst,
    output logic [4:0]  rd,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [31:0] imm,
    output logic [5:0]  inst_code,
    output logic [2:0]  inst_type
);

    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign opc   = inst[6:0];
    assign f3    = inst[14:12];
    assign f7    = inst[31:25];
    assign imm_i = {{20{inst[31]}}, inst[31:20]};
    assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    assign imm_b = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
    assign imm_u = {inst[31:12], 12'b0};
    assign imm_j = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};

    always_comb begin
        rd        = '0;
        rs1       = '0;
        rs2       = '0;
        imm       = '0;
        inst_code = ILLEGAL;
        inst_type = ART;
        case (opc)
            OPC_LUI, OPC_AUIPC: begin
                inst_code = (opc == OPC_LUI) ? LUI : AUIPC;
                inst_type = UPP;
                rd        = inst[11:7];
                imm       = imm_u;
            end
            OPC_JAL: begin
                inst_code = JAL;
                inst_type = JMP;
                rd        = inst[11:7];
                imm       = imm_j;
            end
            OPC_JALR: begin
                if (f3 == 3'b000) begin
                    inst_code = JALR;
                    inst_type = JMP;
                    rd        = inst[11:7];
                    rs1       = inst[19:15];
                    imm       = imm_i;
                end
            end
            OPC_BRANCH: begin
                inst_type = BRC;
                rs1       = inst[19:15];
                rs2       = inst[24:20];
                imm       = imm_b;
                case (f3)
                    3'b000:  inst_code = BEQ;
                    3'b001:  inst_code = BNE;
                    3'b100:  inst_code = BLT;
                    3'b101:  inst_code = BGE;
                    3'b110:  inst_code = BLTU;
                    3'b111:  inst_code = BGEU;
                    default: inst_code = ILLEGAL;
                endcase
            end
            OPC_LOAD: begin
                inst_type = LD;
                rd        = inst[11:7];
                rs1       = inst[19:15];
                imm       = imm_i;
                case (f3)
                    3'b000:  inst_code = LB;
                    3'b001:  inst_code = LH;
                    3'b010:  inst_code = LW;
                    3'b100:  inst_code = LBU;
                    3'b101:  inst_code = LHU;
                    default: inst_code = ILLEGAL;
                endcase
            end
            OPC_STORE: begin
                inst_type = ST;
                rs1       = inst[19:15];
                rs2       = inst[24:20];
                imm       = imm_s;
                case (f3)
                    3'b000:  inst_code = SB;
                    3'b001:  inst_code = SH;
                    3'b010:  inst_code = SW;
                    default: inst_code = ILLEGAL;
                endcase
            end
            OPC_OPIMM: begin
                inst_type = ARTI;
                rd        = inst[11:7];
                rs1       = inst[19:15];
                imm       = imm_i;
                case (f3)
                    3'b000: inst_code = ADDI;
                    3'b010: inst_code = SLTI;
                    3'b011: inst_code = SLTIU;
                    3'b100: inst_code = XORI;
                    3'b110: inst_code = ORI;
                    3'b111: inst_code = ANDI;
                    // Shifts carry only the shift amount; funct7 selects the variant.
                    3'b001: begin
                        imm       = {27'b0, inst[24:20]};
                        inst_code = (f7 == 7'b0000000) ? SLLI : ILLEGAL;
                    end
                    default: begin
                        imm = {27'b0, inst[24:20]};
                        if (f7 == 7'b0000000)      inst_code = SRLI;
                        else if (f7 == 7'b0100000) inst_code = SRAI;
                        else                       inst_code = ILLEGAL;
                    end
                endcase
            end
            OPC_OP: begin
                inst_type = ART;
                rd        = inst[11:7];
                rs1       = inst[19:15];
                rs2       = inst[24:20];
                case ({f7, f3})
                    {7'b0000000, 3'b000}: inst_code = ADD;
                    {7'b0100000, 3'b000}: inst_code = SUB;
                    {7'b0000000, 3'b001}: inst_code = SLL;
                    {7'b0000000, 3'b010}: inst_code = SLT;
                    {7'b0000000, 3'b011}: inst_code = SLTU;
                    {7'b0000000, 3'b100}: inst_code = XOR;
                    {7'b0000000, 3'b101}: inst_code = SRL;
                    {7'b0100000, 3'b101}: inst_code = SRA;
                    {7'b0000000, 3'b110}: inst_code = OR;
                    {7'b0000000, 3'b111}: inst_code = AND;
                    default:              inst_code = ILLEGAL;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/issue_unit.sv
// In-order issue stage: instruction queue, head decode, one registered issue per cycle to RS or LSB.
// Latency: 2 edges fetch-to-issue; 1 edge into an empty queue when ISSUE_BYPASS_EN is defined.
// Backpressure: fetch_ready drops when the queue is full; rob_full/rs_full/lsb_full stall the head.
module issue_unit
    import issue_unit_pkg::*;
#(
    parameter int IQ_DEPTH = 8
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               rdy_in,
    input  logic               fetch_valid,
    input  logic [31:0]        fetch_inst,
    input  logic [31:0]        fetch_pc,
    output logic               fetch_ready,
    input  logic               flush,
    input  logic               rob_full,
    input  logic [ROBIDBW-1:0] rob_id_next,
    input  logic               rs_full,
    input  logic               lsb_full,
    output logic               inst_ID_flag,
    output logic [4:0]         rd,
    output logic [4:0]         rs1,
    output logic [4:0]         rs2,
    output logic [31:0]        imm,
    output logic [5:0]         inst_code,
    output logic [2:0]         inst_type,
    output logic [31:0]        now_pc,
    output logic [ROBIDBW-1:0] issue_rob_id
);

    localparam int PTRW = (IQ_DEPTH > 1) ? $clog2(IQ_DEPTH) : 1;
    localparam int CNTW = PTRW + 1;
    localparam logic [CNTW-1:0] FULL_CNT = CNTW'(IQ_DEPTH);

    logic [31:0]        inst_mem_q [IQ_DEPTH];
    logic [31:0]        inst_mem_d [IQ_DEPTH];
    logic [31:0]        pc_mem_q   [IQ_DEPTH];
    logic [31:0]        pc_mem_d   [IQ_DEPTH];
    logic [PTRW-1:0]    head_q, head_d, tail_q, tail_d;
    logic [CNTW-1:0]    count_q, count_d;

    logic               flag_q, flag_d;
    logic [4:0]         rd_q, rd_d, rs1_q, rs1_d, rs2_q, rs2_d;
    logic [31:0]        imm_q, imm_d, pc_q, pc_d;
    logic [5:0]         code_q, code_d;
    logic [2:0]         type_q, type_d;
    logic [ROBIDBW-1:0] rob_q, rob_d;

    logic [31:0] head_inst;
    logic [4:0]  h_rd, h_rs1, h_rs2;
    logic [31:0] h_imm;
    logic [5:0]  h_code;
    logic [2:0]  h_type;

    logic head_vld, head_blk, push, issue, drop, pop, enq, byp, byp_issue;

    assign head_inst = inst_mem_q[head_q];

    inst_decoder u_head_dec (
        .inst      (head_inst),
        .rd        (h_rd),
        .rs1       (h_rs1),
        .rs2       (h_rs2),
        .imm       (h_imm),
        .inst_code (h_code),
        .inst_type (h_type)
    );

`ifdef ISSUE_BYPASS_EN
    logic [4:0]  f_rd, f_rs1, f_rs2;
    logic [31:0] f_imm;
    logic [5:0]  f_code;
    logic [2:0]  f_type;

    inst_decoder u_fetch_dec (
        .inst      (fetch_inst),
        .rd        (f_rd),
        .rs1       (f_rs1),
        .rs2       (f_rs2),
        .imm       (f_imm),
        .inst_code (f_code),
        .inst_type (f_type)
    );

    // An empty queue lets an unblocked word skip storage; an illegal one is simply not kept.
    assign byp       = push && (count_q == '0) && !rob_full
                       && !(goes_to_lsb(f_type) ? lsb_full : rs_full);
    assign byp_issue = byp && (f_code != ILLEGAL);
`else
    assign byp       = 1'b0;
    assign byp_issue = 1'b0;
`endif

    // Uses the registered count so a same-cycle pop never opens a slot.
    assign fetch_ready = (count_q != FULL_CNT) && !rst_in;

    always_comb begin
        head_vld = (count_q != '0);
        head_blk = rob_full || (goes_to_lsb(h_type) ? lsb_full : rs_full);
        push     = fetch_valid && fetch_ready && rdy_in && !flush;
        issue    = head_vld && (h_code != ILLEGAL) && !head_blk && rdy_in && !flush;
        drop     = head_vld && (h_code == ILLEGAL) && rdy_in && !flush;
        pop      = issue || drop;
        enq      = push && !byp;
    end

    always_comb begin
        inst_mem_d = inst_mem_q;
        pc_mem_d   = pc_mem_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        if (enq) begin
            inst_mem_d[tail_q] = fetch_inst;
            pc_mem_d[tail_q]   = fetch_pc;
            tail_d             = tail_q + PTRW'(1);
        end
        if (pop) begin
            head_d = head_q + PTRW'(1);
        end
        case ({enq, pop})
            2'b10:   count_d = count_q + CNTW'(1);
            2'b01:   count_d = count_q - CNTW'(1);
            default: count_d = count_q;
        endcase
        // A misprediction is never deferred, even while rdy_in is low.
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_comb begin
        flag_d = False;
        rd_d   = rd_q;
        rs1_d  = rs1_q;
        rs2_d  = rs2_q;
        imm_d  = imm_q;
        code_d = code_q;
        type_d = type_q;
        pc_d   = pc_q;
        rob_d  = rob_q;
        if (issue) begin
            flag_d = True;
            rd_d   = h_rd;
            rs1_d  = h_rs1;
            rs2_d  = h_rs2;
            imm_d  = h_imm;
            code_d = h_code;
            type_d = h_type;
            pc_d   = pc_mem_q[head_q];
            rob_d  = rob_id_next;
        end
`ifdef ISSUE_BYPASS_EN
        else if (byp_issue) begin
            flag_d = True;
            rd_d   = f_rd;
            rs1_d  = f_rs1;
            rs2_d  = f_rs2;
            imm_d  = f_imm;
            code_d = f_code;
            type_d = f_type;
            pc_d   = fetch_pc;
            rob_d  = rob_id_next;
        end
`endif
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            flag_q  <= 1'b0;
            rd_q    <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            imm_q   <= '0;
            code_q  <= '0;
            type_q  <= '0;
            pc_q    <= '0;
            rob_q   <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            flag_q  <= flag_d;
            rd_q    <= rd_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            imm_q   <= imm_d;
            code_q  <= code_d;
            type_q  <= type_d;
            pc_q    <= pc_d;
            rob_q   <= rob_d;
        end
    end

    // Storage is only meaningful between head and tail, so it needs no reset.
    always_ff @(posedge clk_in) begin
        inst_mem_q <= inst_mem_d;
        pc_mem_q   <= pc_mem_d;
    end

    assign inst_ID_flag = flag_q;
    assign rd           = rd_q;
    assign rs1          = rs1_q;
    assign rs2          = rs2_q;
    assign imm          = imm_q;
    assign inst_code    = code_q;
    assign inst_type    = type_q;
    assign now_pc       = pc_q;
    assign issue_rob_id = rob_q;

endmodule

// File: tb/tb_issue_unit.sv
// Directed bench for issue_unit: reset, single issue, stalls, full queue, flush, illegal words, rdy_in hold.
module tb_issue_unit;
    import issue_unit_pkg::*;

    logic               clk = 1'b0;
    logic               rst_in = 1'b1;
    logic               rdy_in = 1'b1;
    logic               fetch_valid = 1'b0;
    logic [31:0]        fetch_inst = '0;
    logic [31:0]        fetch_pc = '0;
    logic               fetch_ready;
    logic               flush = 1'b0;
    logic               rob_full = 1'b0;
    logic [ROBIDBW-1:0] rob_id_next = '0;
    logic               rs_full = 1'b0;
    logic               lsb_full = 1'b0;
    logic               inst_ID_flag;
    logic [4:0]         rd, rs1, rs2;
    logic [31:0]        imm;
    logic [5:0]         inst_code;
    logic [2:0]         inst_type;
    logic [31:0]        now_pc;
    logic [ROBIDBW-1:0] issue_rob_id;

    int total = 0;
    int bad   = 0;

    issue_unit #(.IQ_DEPTH(8)) dut (
        .clk_in       (clk),
        .rst_in       (rst_in),
        .rdy_in       (rdy_in),
        .fetch_valid  (fetch_valid),
        .fetch_inst   (fetch_inst),
        .fetch_pc     (fetch_pc),
        .fetch_ready  (fetch_ready),
        .flush        (flush),
        .rob_full     (rob_full),
        .rob_id_next  (rob_id_next),
        .rs_full      (rs_full),
        .lsb_full     (lsb_full),
        .inst_ID_flag (inst_ID_flag),
        .rd           (rd),
        .rs1          (rs1),
        .rs2          (rs2),
        .imm          (imm),
        .inst_code    (inst_code),
        .inst_type    (inst_type),
        .now_pc       (now_pc),
        .issue_rob_id (issue_rob_id)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] addi_word(input int r, input int v);
        return (32'(v) << 20) | (32'(r) << 7) | 32'h13;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_in = 1'b1;
        tick();
        tick();
        total++;
        if (fetch_ready !== 1'b0) begin
            bad++; $display("FAIL reset_fetch_ready got=%0b want=0", fetch_ready);
        end
        total++;
        if ({inst_ID_flag, rd, rs1, rs2, imm, inst_code, inst_type, now_pc, issue_rob_id} !== '0) begin
            bad++; $display("FAIL reset_outputs flag=%0b rd=%0d imm=%h code=%0d pc=%h rob=%0d want all 0",
                            inst_ID_flag, rd, imm, inst_code, now_pc, issue_rob_id);
        end
        rst_in = 1'b0;
        #1;
        total++;
        if (fetch_ready !== 1'b1) begin
            bad++; $display("FAIL post_reset_fetch_ready got=%0b want=1", fetch_ready);
        end
    endtask

    task automatic test_addi();
        rob_id_next = 4'd5;
        fetch_valid = 1'b1;
        fetch_inst  = 32'h00500093;
        fetch_pc    = 32'h0;
        tick();
        fetch_valid = 1'b0;
`ifndef ISSUE_BYPASS_EN
        total++;
        if (inst_ID_flag !== 1'b0) begin
            bad++; $display("FAIL addi_early_flag got=%0b want=0", inst_ID_flag);
        end
        tick();
`endif
        rob_id_next = 4'd7;
        total++;
        if ({inst_ID_flag, rd, rs1, rs2, imm, inst_code, inst_type} !== {1'b1, 5'd1, 5'd0, 5'd0, 32'd5, 6'd19, 3'd1}) begin
            bad++; $display("FAIL addi_issue flag=%0b rd=%0d rs1=%0d rs2=%0d imm=%0d code=%0d type=%0d want 1,1,0,0,5,19,1",
                            inst_ID_flag, rd, rs1, rs2, imm, inst_code, inst_type);
        end
        total++;
        if ({now_pc, issue_rob_id} !== {32'h0, 4'd5}) begin
            bad++; $display("FAIL addi_pc_rob pc=%h rob=%0d want 0,5", now_pc, issue_rob_id);
        end
        tick();
        total++;
        if ({inst_ID_flag, issue_rob_id} !== {1'b0, 4'd5}) begin
            bad++; $display("FAIL addi_pulse flag=%0b rob=%0d want 0,5", inst_ID_flag, issue_rob_id);
        end
    endtask

    task automatic test_store_stall();
        lsb_full    = 1'b1;
        rob_id_next = 4'd3;
        fetch_valid = 1'b1;
        fetch_inst  = 32'h0020A423;
        fetch_pc    = 32'h100;
        tick();
        fetch_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            total++;
            if (inst_ID_flag !== 1'b0) begin
                bad++; $display("FAIL store_stalled cycle=%0d flag=%0b want=0", i, inst_ID_flag);
            end
        end
        lsb_full = 1'b0;
        tick();
        total++;
        if ({inst_ID_flag, rd, rs1, rs2, imm, inst_code, inst_type, now_pc, issue_rob_id} !==
            {1'b1, 5'd0, 5'd1, 5'd2, 32'd8, 6'd18, 3'd6, 32'h100, 4'd3}) begin
            bad++; $display("FAIL store_issue flag=%0b rd=%0d rs1=%0d rs2=%0d imm=%0d code=%0d type=%0d pc=%h rob=%0d want 1,0,1,2,8,18,6,100,3",
                            inst_ID_flag, rd, rs1, rs2, imm, inst_code, inst_type, now_pc, issue_rob_id);
        end
        tick();
        total++;
        if (inst_ID_flag !== 1'b0) begin
            bad++; $display("FAIL store_pulse flag=%0b want=0", inst_ID_flag);
        end
    endtask

    task automatic test_full();
        rs_full = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            fetch_valid = 1'b1;
            fetch_inst  = addi_word(i, i);
            fetch_pc    = 32'(i * 4);
            tick();
        end
        fetch_valid = 1'b0;
        total++;
        if ({fetch_ready, inst_ID_flag} !== 2'b00) begin
            bad++; $display("FAIL full_ready ready=%0b flag=%0b want 0,0", fetch_ready, inst_ID_flag);
        end
        rs_full = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            total++;
            if ({inst_ID_flag, rd, imm, now_pc} !== {1'b1, 5'(i), 32'(i), 32'(i * 4)}) begin
                bad++; $display("FAIL full_drain n=%0d flag=%0b rd=%0d imm=%0d pc=%h want 1,%0d,%0d,%h",
                                i, inst_ID_flag, rd, imm, now_pc, i, i, i * 4);
            end
        end
        tick();
        total++;
        if ({inst_ID_flag, fetch_ready} !== 2'b01) begin
            bad++; $display("FAIL full_drained flag=%0b ready=%0b want 0,1", inst_ID_flag, fetch_ready);
        end
    endtask

    task automatic test_flush();
        rs_full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            fetch_valid = 1'b1;
            fetch_inst  = addi_word(12 + i, 12 + i);
            fetch_pc    = 32'h200 + 32'(i * 4);
            tick();
        end
        fetch_inst = addi_word(15, 15);
        flush      = 1'b1;
        tick();
        flush       = 1'b0;
        fetch_valid = 1'b0;
        total++;
        if ({dut.count_q, fetch_ready} !== {4'd0, 1'b1}) begin
            bad++; $display("FAIL flush_state count=%0d ready=%0b want 0,1", dut.count_q, fetch_ready);
        end
        rs_full = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (inst_ID_flag !== 1'b0) begin
                bad++; $display("FAIL flush_no_issue cycle=%0d flag=%0b want=0", i, inst_ID_flag);
            end
        end
    endtask

    task automatic test_illegal();
        fetch_valid = 1'b1;
        fetch_inst  = 32'hFFFFFFFF;
        fetch_pc    = 32'h300;
        tick();
        fetch_inst  = 32'h00700193;
        fetch_pc    = 32'h304;
        tick();
        fetch_valid = 1'b0;
        total++;
        if (inst_ID_flag !== 1'b0) begin
            bad++; $display("FAIL illegal_issued flag=%0b want=0", inst_ID_flag);
        end
        tick();
        total++;
        if ({inst_ID_flag, rd, imm, inst_code, now_pc} !== {1'b1, 5'd3, 32'd7, 6'd19, 32'h304}) begin
            bad++; $display("FAIL illegal_then_addi flag=%0b rd=%0d imm=%0d code=%0d pc=%h want 1,3,7,19,304",
                            inst_ID_flag, rd, imm, inst_code, now_pc);
        end
        tick();
        total++;
        if (inst_ID_flag !== 1'b0) begin
            bad++; $display("FAIL illegal_extra_issue flag=%0b want=0", inst_ID_flag);
        end
    endtask

    task automatic test_rdy_hold();
        logic [4:0] rd_before;
        rs_full = 1'b1;
        for (int i = 0; i < 2; i++) begin
            fetch_valid = 1'b1;
            fetch_inst  = addi_word(10 + i, 10 + i);
            fetch_pc    = 32'h400 + 32'(i * 4);
            tick();
        end
        rd_before  = rd;
        rdy_in     = 1'b0;
        rs_full    = 1'b0;
        fetch_inst = addi_word(20, 20);
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if ({inst_ID_flag, dut.count_q, rd} !== {1'b0, 4'd2, rd_before}) begin
                bad++; $display("FAIL rdy_hold cycle=%0d flag=%0b count=%0d rd=%0d want 0,2,%0d",
                                i, inst_ID_flag, dut.count_q, rd, rd_before);
            end
        end
        rdy_in      = 1'b1;
        fetch_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            total++;
            if ({inst_ID_flag, rd} !== {1'b1, 5'(10 + i)}) begin
                bad++; $display("FAIL rdy_release n=%0d flag=%0b rd=%0d want 1,%0d", i, inst_ID_flag, rd, 10 + i);
            end
        end
        tick();
        total++;
        if (inst_ID_flag !== 1'b0) begin
            bad++; $display("FAIL rdy_stray_issue flag=%0b want=0", inst_ID_flag);
        end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 4; k++) begin
            fetch_valid = (k < 3);
            fetch_inst  = addi_word(20 + k, 20 + k);
            fetch_pc    = 32'h500 + 32'(k * 4);
            rob_id_next = ROBIDBW'(k + 1);
            tick();
            if (k > 0) begin
                total++;
                if ({inst_ID_flag, rd, now_pc, issue_rob_id} !==
                    {1'b1, 5'(20 + k - 1), 32'h500 + 32'((k - 1) * 4), ROBIDBW'(k + 1)}) begin
                    bad++; $display("FAIL b2b n=%0d flag=%0b rd=%0d pc=%h rob=%0d want 1,%0d,%h,%0d",
                                    k, inst_ID_flag, rd, now_pc, issue_rob_id, 20 + k - 1, 32'h500 + (k - 1) * 4, k + 1);
                end
            end
        end
        fetch_valid = 1'b0;
        tick();
        total++;
        if (inst_ID_flag !== 1'b0) begin
            bad++; $display("FAIL b2b_tail flag=%0b want=0", inst_ID_flag);
        end
    endtask

    task automatic test_mid_reset();
        rs_full = 1'b1;
        for (int i = 0; i < 2; i++) begin
            fetch_valid = 1'b1;
            fetch_inst  = addi_word(25 + i, 25 + i);
            fetch_pc    = 32'h600 + 32'(i * 4);
            tick();
        end
        fetch_valid = 1'b0;
        rst_in      = 1'b1;
        tick();
        total++;
        if ({fetch_ready, inst_ID_flag, rd, imm, now_pc, issue_rob_id} !== '0) begin
            bad++; $display("FAIL mid_reset ready=%0b flag=%0b rd=%0d imm=%0d pc=%h rob=%0d want all 0",
                            fetch_ready, inst_ID_flag, rd, imm, now_pc, issue_rob_id);
        end
        rst_in  = 1'b0;
        rs_full = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            total++;
            if ({inst_ID_flag, dut.count_q} !== {1'b0, 4'd0}) begin
                bad++; $display("FAIL mid_reset_discard cycle=%0d flag=%0b count=%0d want 0,0", i, inst_ID_flag, dut.count_q);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_addi();
        test_store_stall();
        test_full();
        test_flush();
        test_illegal();
        test_rdy_hold();
        test_back_to_back();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/issue_unit.md
# issue_unit

In-order issue stage of the Tomasulo core. It buffers fetched instruction words in a small queue, decodes the head entry, and issues one instruction per cycle to the reservation station (types up to `BRC`) or to the load/store buffer. Each issued instruction is tagged with the ROB slot allocated to it. It is the transmitting end of the station's issue interface (`inst_ID_flag`, `rd`/`rs1`/`rs2`, `imm`, `inst_code`, `inst_type`, `now_pc`).

## Interface
Parameters:
- `IQ_DEPTH`, default 8: instruction queue entries; must be a power of 2, at least 2.

Ports:
- `clk_in`  in  1  clock; all state updates on the rising edge.
- `rst_in`  in  1  synchronous, active-high reset.
- `rdy_in`  in  1  global ready; when low, all state holds.
- `fetch_valid`  in  1  fetch offers a word this cycle.
- `fetch_inst`  in  32  instruction word.
- `fetch_pc`  in  32  PC of `fetch_inst`.
- `fetch_ready`  out  1  the queue accepts a word this cycle.
- `flush`  in  1  misprediction; discard all queued and in-flight words.
- `rob_full`  in  1  ROB cannot allocate.
- `rob_id_next`  in  `ROBIDBW`  tag the ROB assigns to the next allocation.
- `rs_full`  in  1  reservation station has no free entry.
- `lsb_full`  in  1  load/store buffer has no free entry.
- `inst_ID_flag`  out  1  an issue is valid this cycle; one-cycle pulse per instruction.
- `rd`, `rs1`, `rs2`  out  5 each  register fields; unused fields read 0.
- `imm`  out  32  sign-extended immediate.
- `inst_code`  out  6  instruction enumeration.
- `inst_type`  out  3  class selector.
- `now_pc`  out  32  PC of the issued instruction.
- `issue_rob_id`  out  `ROBIDBW`  ROB tag of the issued instruction.

## Operation
- **Queue.** Circular FIFO with head/tail pointers and a count of width log2(`IQ_DEPTH`)+1. Pointers wrap modulo `IQ_DEPTH`.
- **`fetch_ready`.** Equals `(count != IQ_DEPTH) && !rst_in`. It is computed from the registered count only, so a pop in the same cycle does not free a slot.
- **Push.** A push occurs when `fetch_valid && fetch_ready && rdy_in && !flush`.
- **Decoder.** The head entry is decoded combinationally. Immediates follow RV32I formats. U-type immediates are `{inst[31:12], 12'b0}`. Fields not used by the format read 0 (for example `rs2` for I-type, `rd` for S/B-type).
- **`inst_code` enumeration.**
  - LUI=1, AUIPC=2, JAL=3, JALR=4
  - BEQ..BGEU=5..10
  - LB,LH,LW,LBU,LHU=11..15
  - SB,SH,SW=16..18
  - ADDI..SRAI=19..27 in ISA table order
  - ADD..AND=28..37
  - 0 means illegal.
- **`inst_type` enumeration.** ART=0, ARTI=1, UPP=2, JMP=3, BRC=4, LD=5, ST=6.
- **Illegal head** (code 0): popped with no issue and no ROB allocation; costs one cycle.
- **Issue condition.** Issue happens when the head is valid, the code is legal, `!rob_full`, the target station is not full (`rs_full` if type ≤ BRC, otherwise `lsb_full`), `rdy_in` is high and `flush` is low. On issue:
  - the head is popped;
  - all outputs are registered from the decoder;
  - `issue_rob_id` is latched from `rob_id_next`.
- **No issue.** At any edge without an issue, `inst_ID_flag` is registered to 0 and the other outputs hold. This includes edges where `rdy_in` is low.
- **Flush.** At an edge with `flush` high: count and both pointers go to 0 and `inst_ID_flag` goes to 0. A fetch offered in the same cycle is dropped. Flush has priority over push and issue.
- **Reset.** At an edge with `rst_in` high:
  - all outputs are 0, including `inst_ID_flag`;
  - count, head and tail are 0;
  - `fetch_ready` is 0 while `rst_in` is high.
  - Reset mid-stream discards everything.

## Timing
- **Base latency.** A word pushed at edge N is decoded in cycle N+1 and issued at edge N+1, so `inst_ID_flag` is high in the cycle after edge N+1.
- **Throughput.** One issue per cycle while unblocked. Push and pop can occur at the same edge whenever the queue is not full.
- **Stalls.** A stall holds the head indefinitely. Issue order always equals fetch order.

## Configuration
- **`ISSUE_BYPASS_EN` defined:** when count = 0, the issue conditions hold for the incoming word, and a push would occur, the fetched word goes directly to the output registers at the push edge. Nothing is enqueued and latency is 1 edge. Illegal words are dropped on bypass.
- **`ISSUE_BYPASS_EN` undefined:** every word passes through the queue; latency is 2 edges.

## Structure
- **Shared definitions header.** Holds:
  - `inst_type` constants (ART..ST, with `BRC`=4);
  - `inst_code` constants;
  - RV32I opcode values;
  - `ROBIDBW`, `RSSZ`, `True`/`False`.
- **Sub-module `inst_decoder`.** Purely combinational: a 32-bit word in; `rd`, `rs1`, `rs2`, `imm`, `inst_code` and `inst_type` out.
- **`issue_unit` top.** Holds the queue, issue control and output registers.

## Test plan
- Push `0x00500093` (addi x1,x0,5) at PC 0x0 -> `inst_ID_flag` high one cycle after the following edge; rd=1, rs1=0, rs2=0, imm=5, code=19, type=1, `issue_rob_id`=`rob_id_next`.
- Push `0x0020A423` (sw x2,8(x1)) with `lsb_full`=1 for 5 cycles -> no flag. Drop `lsb_full` -> one flag pulse with rs1=1, rs2=2, rd=0, imm=8, code=18, type=6.
- Hold `rs_full`=1 and push 8 ALU words -> `fetch_ready` is 0 after the 8th push. Release -> 8 flag pulses on consecutive cycles, in push order.
- Queue 3 words, then assert `flush` for one cycle -> count 0, no flag pulses, `fetch_ready` 1 on the next cycle.
- Push `0xFFFFFFFF` followed by a valid addi -> only the addi issues, one cycle later than it would without the illegal word.
- Hold `rdy_in`=0 with 2 words queued -> no flag and the state is unchanged. With `ISSUE_BYPASS_EN` defined, a push into an empty queue raises the flag after 1 edge.
